btn_conditioner: RTL
====================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable clk cycles required to accept a new button level (10 ms at 100 MHz); legal range 2..2^24.
REQ-002 clk  input  1  system clock, 100 MHz board clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 btn_in  input  5  raw asynchronous push-buttons, bit order {btnU, btnD, btnR, btnL, btnC} = [4:0]; 1 = pressed.
REQ-005 btn_level  output  5  debounced, registered button level, same bit order.
REQ-006 btn_press  output  5  one-cycle pulse per accepted 0->1 transition, same bit order.
REQ-007 any_press  output  1  OR of btn_press, registered alongside it in the same cycle.

Function
REQ-008 Each bit shall pass through a 2-flop synchronizer; no other logic shall sample btn_in directly.
REQ-009 Each bit shall own an independent debounce counter of width ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-010 Counter rule per bit: synchronized value equal to btn_level -> counter cleared to 0; not equal -> counter increments by 1.
REQ-011 When the counter equals DEBOUNCE_CYCLES-1 and the synchronized value still differs, btn_level shall take the synchronized value and the counter shall clear to 0.
REQ-012 Latency: btn_in held at a new value from sampling edge 1 onward -> btn_level updates on edge DEBOUNCE_CYCLES+2.
REQ-013 btn_press[i] shall be 1 for exactly the single cycle in which btn_level[i] goes 0->1, and 0 otherwise.
REQ-014 Any reversion of the synchronized value before acceptance shall clear the counter; a glitch shorter than DEBOUNCE_CYCLES cycles after synchronization shall never change btn_level.
REQ-015 Counters shall never wrap; acceptance at DEBOUNCE_CYCLES-1 is the only exit from counting.
REQ-016 Bits are fully independent; simultaneous presses on several buttons shall assert the corresponding btn_press bits in the same cycle.
REQ-017 A button held continuously shall produce exactly one btn_press pulse, with no auto-repeat.

Reset
REQ-018 While rst_n=0: synchronizer flops, counters, btn_level, btn_press and any_press shall be 0, asynchronously.
REQ-019 Reset deassertion shall be synchronized internally so that all bits leave reset on the same clk edge.
REQ-020 A button already held at reset release shall be debounced as a new press and shall yield one btn_press pulse after the REQ-012 latency.
REQ-021 Reset asserted mid-count shall discard the count; no pulse shall be emitted for that transition.

Configuration
REQ-022 Macro BTN_RELEASE_PULSE_EN: when defined, add output btn_release (5 bits, same order), a one-cycle pulse on each accepted 1->0 transition of btn_level, reset 0, and any_press shall not include releases.
REQ-023 Without BTN_RELEASE_PULSE_EN, the btn_release port and its logic shall be absent.

Verification (DEBOUNCE_CYCLES=16)
REQ-024 Clean press: btn_in[1] 0->1 held 40 cycles -> btn_level[1]=1 on edge 18; btn_press[1] and any_press high for exactly that one cycle.
REQ-025 Bounce: btn_in[0] toggles every 5 cycles for 60 cycles, then holds 1 -> no btn_level change during the bounce; one press pulse 18 edges after the final toggle.
REQ-026 Simultaneous press: btn_in=5'b10110 on one edge -> btn_press=5'b10110 in a single cycle, any_press=1 once.
REQ-027 Reset mid-count: btn_in[3]=1, rst_n pulled low at cycle 10, released at cycle 12 -> outputs 0 during reset; one press at the REQ-020 latency after release.
REQ-028 Release with BTN_RELEASE_PULSE_EN: press accepted, then btn_in[2] 1->0 -> btn_release[2] pulses once 18 edges later, btn_press stays 0, any_press stays 0.

Source files
------------

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - five-button synchronizer, debouncer and press-pulse generator
//
// Purpose:
//   Conditions five raw push-buttons. Each bit is synchronized by two flops and
//   then debounced by its own counter. A new level is accepted only after it has
//   been stable for DEBOUNCE_CYCLES consecutive clocks. Each accepted 0->1
//   transition produces a one-cycle btn_press pulse. any_press is the OR of those
//   pulses, registered in the same cycle.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable clocks needed to accept a new level (2 .. 2**24)
//
// Ports:
//   clk          system clock; all logic runs on the rising edge
//   rst_n        asynchronous active-low reset
//   btn_in[4:0]  raw buttons {btnU, btnD, btnR, btnL, btnC}; 1 = pressed
//   btn_level    debounced, registered level, same bit order
//   btn_press    one-cycle pulse for each accepted 0->1 transition
//   any_press    OR of btn_press, registered alongside it
//   btn_release  one-cycle pulse for each accepted 1->0 transition
//                (present only with BTN_RELEASE_PULSE_EN)
//
// Configuration macro:
//   BTN_RELEASE_PULSE_EN  adds the btn_release output and its logic

module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_in,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic       any_press
`ifdef BTN_RELEASE_PULSE_EN
  ,
  output logic [4:0] btn_release
`endif
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The reset is asserted asynchronously and released through two flops, so
  // every counter and output bit leaves reset on the same clock edge. The input
  // synchronizer runs from the raw reset. It therefore already holds a valid
  // sample when the counters are released. A button held through reset then
  // takes the normal DEBOUNCE_CYCLES+2 latency, counted from the release edge.
  logic [1:0] rst_pipe;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_int_n = rst_pipe[1];

  // Two-flop synchronizer. This is the only logic that samples btn_in.
  logic [4:0] sync_q1;
  logic [4:0] sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 5'b0;
      sync_q2 <= 5'b0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  // Per-bit debounce counters. A counter runs only while the synchronized value
  // differs from the accepted level. Any reversion clears the counter. Reaching
  // CNT_MAX is the only way out of counting, so a counter can never wrap.
  logic [4:0] accept;

  for (genvar i = 0; i < 5; i++) begin : g_bit
    logic [CNT_W-1:0] cnt;
    logic             differs;

    assign differs   = sync_q2[i] ^ btn_level[i];
    assign accept[i] = differs && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        cnt <= '0;
      end else if (!differs || accept[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Acceptance flips the level. The edge direction comes from the synchronized
  // value that was accepted.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      btn_level <= 5'b0;
      btn_press <= 5'b0;
      any_press <= 1'b0;
    end else begin
      btn_level <= btn_level ^ accept;
      btn_press <= accept & sync_q2;
      any_press <= |(accept & sync_q2);
    end
  end

`ifdef BTN_RELEASE_PULSE_EN
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      btn_release <= 5'b0;
    end else begin
      btn_release <= accept & ~sync_q2;
    end
  end
`endif

endmodule
